// File: rtl/regfile_wport_ctrl_pkg.sv
// Shared constants and types for the register-file write-port controller.
package regfile_wport_ctrl_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } late_entry_t;

endpackage

// File: rtl/regfile_wport_ctrl_fifo.sv
// Small synchronous FIFO holding late writebacks until the port is free.
module late_wb_fifo
  import regfile_wport_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  late_entry_t                    din,
  output late_entry_t                    head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  late_entry_t   mem [DEPTH];
  logic [PW-1:0] rd;
  logic [PW-1:0] wr;

  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wrap(wr);
      if (pop)  rd <= wrap(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd];

endmodule

// File: rtl/regfile_wport_ctrl.sv
// Single write-port owner: clears x1..x31 after reset, then merges
// WB-stage writes with queued late writebacks under a starvation guard.
module regfile_wport_ctrl
  import regfile_wport_ctrl_pkg::*;
#(
  parameter int LATE_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              late_valid,
  output logic              late_ready,
  input  logic [ADDR_W-1:0] late_addr,
  input  logic [DATA_W-1:0] late_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_din,
  output logic              init_busy,
  output logic              wb_stall,
  output logic              late_pending
);

  localparam int CW = $clog2(LATE_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int IW = ADDR_W + 1;
  localparam logic [CW-1:0] FULL     = CW'(LATE_DEPTH);
  localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);
  localparam logic [IW-1:0] INIT_END = IW'(NUM_REGS);

  state_t        state;
  state_t        state_d;
  logic [IW-1:0] init_cnt;
  logic [IW-1:0] init_cnt_d;
  logic [SW-1:0] starve;
  logic [SW-1:0] starve_d;
  logic [CW-1:0] count;
  logic [CW-1:0] count_d;
  late_entry_t   head;
  late_entry_t   din;
  logic          push;
  logic          pop;
  logic          wb_go;
  logic          nonempty;
  logic          init_wr;

  logic              rf_we_d;
  logic [ADDR_W-1:0] rf_addr_d;
  logic [DATA_W-1:0] rf_din_d;
  logic              init_busy_d;
  logic              late_ready_d;
  logic              wb_stall_d;
  logic              late_pending_d;

  late_wb_fifo #(
    .DEPTH (LATE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign din      = '{addr: late_addr, data: late_data};
  assign nonempty = (count != '0);
  assign init_wr  = (state == INIT) && (init_cnt != INIT_END);
  // x0 targets are dropped on both sources so they never use the port
  assign push     = late_valid & late_ready & (late_addr != '0);
  assign wb_go    = (state == RUN) & ~wb_stall & wb_we & (wb_addr != '0);
  assign pop      = (state == RUN) & nonempty & ~wb_go;
  assign count_d  = count + CW'(push) - CW'(pop);
  assign starve_d = (pop || !nonempty) ? '0 : starve + SW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      init_cnt <= IW'(1);
      starve   <= '0;
    end else begin
      state    <= state_d;
      init_cnt <= init_cnt_d;
      starve   <= starve_d;
    end
  end

  always_comb begin
    state_d    = state;
    init_cnt_d = init_cnt;
    unique case (state)
      INIT: begin
        if (init_cnt == INIT_END) state_d = RUN;
        else init_cnt_d = init_cnt + IW'(1);
      end
      RUN: state_d = RUN;
    endcase
  end

  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr;
    rf_din_d  = rf_din;
    unique case (1'b1)
      init_wr: begin
        rf_we_d   = 1'b1;
        rf_addr_d = init_cnt[ADDR_W-1:0];
        rf_din_d  = '0;
      end
      wb_go: begin
        rf_we_d   = 1'b1;
        rf_addr_d = wb_addr;
        rf_din_d  = wb_data;
      end
      pop: begin
        rf_we_d   = 1'b1;
        rf_addr_d = head.addr;
        rf_din_d  = head.data;
      end
      default: ;
    endcase
    init_busy_d    = (state_d == INIT);
    late_ready_d   = (state_d == RUN) && (count_d < FULL);
    wb_stall_d     = (state == RUN) && (starve_d == LIMIT);
    late_pending_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we        <= 1'b0;
      rf_addr      <= '0;
      rf_din       <= '0;
      init_busy    <= 1'b1;
      late_ready   <= 1'b0;
      wb_stall     <= 1'b0;
      late_pending <= 1'b0;
    end else begin
      rf_we        <= rf_we_d;
      rf_addr      <= rf_addr_d;
      rf_din       <= rf_din_d;
      init_busy    <= init_busy_d;
      late_ready   <= late_ready_d;
      wb_stall     <= wb_stall_d;
      late_pending <= late_pending_d;
    end
  end

endmodule

// File: tb/tb_regfile_wport_ctrl.sv
// Randomised bench for regfile_wport_ctrl against a queue-based model.
module tb_regfile_wport_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        late_valid = 1'b0;
  logic        late_ready;
  logic [4:0]  late_addr = '0;
  logic [31:0] late_data = '0;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_din;
  logic        init_busy;
  logic        wb_stall;
  logic        late_pending;

  int n_cmp = 0;
  int n_fail = 0;

  regfile_wport_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .late_valid   (late_valid),
    .late_ready   (late_ready),
    .late_addr    (late_addr),
    .late_data    (late_data),
    .rf_we        (rf_we),
    .rf_addr      (rf_addr),
    .rf_din       (rf_din),
    .init_busy    (init_busy),
    .wb_stall     (wb_stall),
    .late_pending (late_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  // Reference model: a plain queue plus a waiting-age counter
  ent_t        q[$];
  int          m_next;
  bit          m_run;
  int          m_wait;
  logic        e_we, e_busy, e_ready, e_stall, e_pend;
  logic [4:0]  e_addr;
  logic [31:0] e_din;

  localparam logic [41:0] RST_VEC = {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};

  function automatic logic [41:0] obs();
    return {rf_we, rf_addr, rf_din, init_busy, late_ready, wb_stall, late_pending};
  endfunction

  function automatic logic [41:0] expv();
    return {e_we, e_addr, e_din, e_busy, e_ready, e_stall, e_pend};
  endfunction

  task automatic model_reset();
    q.delete();
    m_next = 1; m_run = 0; m_wait = 0;
    e_we = 0; e_addr = '0; e_din = '0;
    e_busy = 1; e_ready = 0; e_stall = 0; e_pend = 0;
  endtask

  task automatic model_step();
    bit   had;
    bit   popped;
    ent_t e;
    if (!m_run) begin
      if (m_next < 32) begin
        e_we = 1; e_addr = m_next[4:0]; e_din = '0; m_next++;
      end else begin
        m_run = 1; e_we = 0;
      end
      e_busy = !m_run; e_ready = m_run; e_stall = 0; e_pend = 0;
      return;
    end
    had = (q.size() != 0);
    popped = 0;
    if (!e_stall && wb_we && wb_addr != 0) begin
      e_we = 1; e_addr = wb_addr; e_din = wb_data;
    end else if (had) begin
      e = q.pop_front();
      e_we = 1; e_addr = e.a; e_din = e.d; popped = 1;
    end else begin
      e_we = 0;
    end
    if (late_valid && e_ready && late_addr != 0) q.push_back('{late_addr, late_data});
    m_wait = (popped || !had) ? 0 : m_wait + 1;
    e_stall = (m_wait == 4);
    e_ready = (q.size() < 2);
    e_pend = (q.size() != 0);
  endtask

  task automatic cycle(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld);
    @(negedge clk);
    wb_we = we; wb_addr = wa; wb_data = wd;
    late_valid = lv; late_addr = la; late_data = ld;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs() !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %h want %h", obs(), RST_VEC);
    end
    release_reset();
  endtask

  task automatic test_init();
    int nwr = 0;
    int bad = 0;
    for (int i = 0; i < 32; i++) begin
      cycle($urandom_range(0, 1), 5'($urandom), $urandom,
            $urandom_range(0, 1), 5'($urandom), $urandom);
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL init_cyc%0d: got %h want %h", i, obs(), expv());
      end
      if (rf_we) begin
        nwr++;
        if (i > 30 || rf_addr !== 5'(i + 1) || rf_din !== 32'd0) bad++;
      end
    end
    n_cmp++;
    if (nwr != 31 || bad != 0) begin
      n_fail++;
      $display("FAIL init_sequence: writes %0d bad %0d want 31 and 0", nwr, bad);
    end
    n_cmp++;
    if ({init_busy, late_ready, rf_we} !== 3'b010) begin
      n_fail++;
      $display("FAIL init_exit: busy/ready/we %b want 010", {init_busy, late_ready, rf_we});
    end
  endtask

  task automatic test_wb_write();
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    n_cmp++;
    if ({rf_we, rf_addr, rf_din} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL wb_write: got %h want %h", {rf_we, rf_addr, rf_din},
               {1'b1, 5'd5, 32'hDEADBEEF});
    end
    cycle(1, 5'd0, 32'h12345678, 0, 5'd0, 32'd0);
    n_cmp++;
    if ({rf_we, rf_addr, rf_din} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL wb_x0_drop: got %h want %h", {rf_we, rf_addr, rf_din},
               {1'b0, 5'd5, 32'hDEADBEEF});
    end
  endtask

  task automatic test_late_order();
    cycle(0, 5'd0, 32'd0, 1, 5'd7, 32'h11);
    cycle(0, 5'd0, 32'd0, 1, 5'd8, 32'h22);
    n_cmp++;
    if ({rf_we, rf_addr, rf_din} !== {1'b1, 5'd7, 32'h11}) begin
      n_fail++;
      $display("FAIL late_first: got %h want %h", {rf_we, rf_addr, rf_din},
               {1'b1, 5'd7, 32'h11});
    end
    idle();
    n_cmp++;
    if ({rf_we, rf_addr, rf_din, late_pending} !== {1'b1, 5'd8, 32'h22, 1'b0}) begin
      n_fail++;
      $display("FAIL late_second: got %h want %h", {rf_we, rf_addr, rf_din, late_pending},
               {1'b1, 5'd8, 32'h22, 1'b0});
    end
    cycle(1, 5'd4, 32'hA, 1, 5'd10, 32'h10);
    cycle(1, 5'd4, 32'hB, 1, 5'd11, 32'h11);
    n_cmp++;
    if ({late_ready, late_pending} !== 2'b01) begin
      n_fail++;
      $display("FAIL late_full: ready/pending %b want 01", {late_ready, late_pending});
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL late_drain%0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_starvation();
    int stall_at = -1;
    int nstall = 0;
    bit prev_stall = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 5'd3, $urandom, i == 0, 5'd9, 32'h99);
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL starve_cyc%0d: got %h want %h", i, obs(), expv());
      end
      if (prev_stall) begin
        n_cmp++;
        if ({rf_we, rf_addr, rf_din} !== {1'b1, 5'd9, 32'h99}) begin
          n_fail++;
          $display("FAIL starve_issue: got %h want %h", {rf_we, rf_addr, rf_din},
                   {1'b1, 5'd9, 32'h99});
        end
      end
      if (wb_stall) begin
        nstall++;
        if (stall_at < 0) stall_at = i;
      end
      prev_stall = wb_stall;
    end
    n_cmp++;
    if (stall_at != 4 || nstall != 1) begin
      n_fail++;
      $display("FAIL starve_timing: first %0d count %0d want 4 and 1", stall_at, nstall);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 9) < 6,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom,
            $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom);
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got %h want %h", i, obs(), expv());
      end
    end
    repeat (8) idle();
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    model_reset();
    release_reset();
    for (int i = 0; i < 12; i++) idle();
    n_cmp++;
    if ({rf_we, rf_addr, init_busy} !== {1'b1, 5'd12, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_init_pre: got %h want %h", {rf_we, rf_addr, init_busy},
               {1'b1, 5'd12, 1'b1});
    end
    #1 reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (obs() !== RST_VEC) begin
      n_fail++;
      $display("FAIL mid_init_reset: got %h want %h", obs(), RST_VEC);
    end
    release_reset();
    for (int i = 0; i < 32; i++) begin
      idle();
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL reinit_cyc%0d: got %h want %h", i, obs(), expv());
      end
    end
    cycle(1, 5'd3, 32'h1, 1, 5'd12, 32'hC);
    cycle(1, 5'd3, 32'h2, 1, 5'd13, 32'hD);
    n_cmp++;
    if ({late_ready, late_pending} !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_run_pre: ready/pending %b want 01", {late_ready, late_pending});
    end
    #1 reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (obs() !== RST_VEC) begin
      n_fail++;
      $display("FAIL mid_run_reset: got %h want %h", obs(), RST_VEC);
    end
    release_reset();
    for (int i = 0; i < 34; i++) begin
      idle();
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL rerun_cyc%0d: got %h want %h", i, obs(), expv());
      end
    end
    n_cmp++;
    if ({rf_we, late_pending, late_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL fifo_flushed: we/pending/ready %b want 001",
               {rf_we, late_pending, late_ready});
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_wb_write();
    test_late_order();
    test_starvation();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wport_ctrl.md
Name: regfile_wport_ctrl

Overview:
- Owns the single write port (we / D_addr / Rin) of the 32x32 RegisterFile in the RV32I pipeline.
- After reset it runs an init sequencer that clears x1..x31.
- It then arbitrates between two sources:
  - the pipeline WB stage, which has priority and no backpressure;
  - a late-writeback source (load return / multi-cycle unit), which uses valid/ready and a small FIFO.
- A starvation guard stalls WB so that late writes always drain.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NUM_REGS, 32, register count; x0 is never written
- LATE_DEPTH, 2, late-writeback FIFO entries
- STARVE_LIMIT, 4, consecutive cycles a FIFO head may wait before WB is stalled

Ports:
- clk in 1: rising-edge clock
- reset in 1: asynchronous, active-low reset
- wb_we in 1: WB-stage write request
- wb_addr in ADDR_W: WB destination register
- wb_data in DATA_W: WB data
- late_valid in 1: late write offered
- late_ready out 1: FIFO can accept
- late_addr in ADDR_W: late destination register
- late_data in DATA_W: late data
- rf_we out 1: to RegisterFile we
- rf_addr out ADDR_W: to RegisterFile D_addr
- rf_din out DATA_W: to RegisterFile Rin
- init_busy out 1: init in progress; pipeline must hold
- wb_stall out 1: pipeline must hold the WB stage this cycle
- late_pending out 1: FIFO non-empty; used by the hazard unit

Behaviour:
- All outputs are registered.
- Reset values (reset=0):
  - rf_we=0, rf_addr=0, rf_din=0
  - init_busy=1, late_ready=0, wb_stall=0, late_pending=0
  - FIFO empty, starvation counter 0, state INIT, init counter 1
- Reset asserted at any time: the FIFO contents are discarded and INIT restarts from x1.
- State INIT:
  - Edge k (k=0..30) after reset release drives rf_we=1, rf_addr=k+1, rf_din=0.
  - When the counter issues address NUM_REGS-1, the next edge moves to RUN and clears init_busy and rf_we.
  - wb_we is ignored; late_ready=0.
  - Exactly 31 writes are issued; address 0 is never driven with rf_we=1.
- State RUN: the selection at each edge, in priority order, is:
  1. wb_stall currently high → issue the FIFO head (pop). wb_we is ignored this cycle; the pipeline holds it.
  2. wb_we=1 and wb_addr≠0 → issue the WB write.
  3. FIFO non-empty → issue the head (pop).
  4. Otherwise → rf_we=0; rf_addr and rf_din hold their values.
- wb_we with wb_addr=0 is dropped, does not occupy the port, and the FIFO may drain that cycle.
- Latency:
  - A WB request sampled at edge N appears on rf_* after edge N.
  - A late entry accepted at edge N is eligible at edge N+1 at the earliest, i.e. it reaches rf_* after edge N+1.
- Late handshake:
  - Accept = late_valid & late_ready.
  - late_ready = (count < LATE_DEPTH) & RUN, registered from the post-edge count.
  - late_addr=0 is accepted and discarded, not enqueued.
- FIFO pointers wrap modulo LATE_DEPTH.
  - Push and pop in the same edge leave the count unchanged.
  - A push is never attempted when full (ready is low).
- late_pending = count≠0.
- Starvation guard:
  - The counter increments on each edge where the FIFO is non-empty and its head is not popped.
  - The counter clears on pop, or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, wb_stall is 1 for exactly the following cycle, then returns to 0.
- The controller does not reorder or squash same-address writes. The hazard unit must stall on late_pending when needed.

Decomposition:
- Shared package: ADDR_W, DATA_W, NUM_REGS constants and the state enum {INIT, RUN}.
- One natural sub-module: late_wb_fifo, a parameterised LATE_DEPTH sync FIFO with push/pop/count, reset async active-low.

Test Plan:
- Reset release, no requests:
  - 31 consecutive cycles with rf_we=1, rf_addr=1..31, rf_din=0.
  - init_busy falls the cycle after addr 31; late_ready rises at the same time.
- RUN, wb_we=1, wb_addr=5, wb_data=0xDEADBEEF → next cycle rf_we=1, rf_addr=5, rf_din=0xDEADBEEF.
- wb_addr=0 with wb_we=1 → rf_we=0.
- Late push (addr 7, data 0x11), then (addr 8, data 0x22), with no WB:
  - Writes appear in order x7 then x8, each one edge after eligibility.
  - late_ready drops while count=2.
  - late_pending clears after the second pop.
- Late entry queued while wb_we=1 every cycle to addr 3:
  - After 4 waiting cycles wb_stall=1 for one cycle, the late entry is issued in that cycle, and the WB write is not issued that cycle.
- Assert reset mid-INIT (at addr 12) and mid-RUN with 2 entries queued:
  - All outputs return to their reset values.
  - The FIFO is empty and INIT restarts at x1 after release.
